// File: rtl/start_fifo_srl_ctrl.sv
// Control for an SRL-backed FIFO with a registered head stage.
// Capacity is DEPTH entries in the external SRL plus one in the head register.
module start_fifo_srl_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH+1:0] usedw,
  output logic                  shift_we,
  output logic [ADDR_WIDTH-1:0] shift_addr,
  output logic [DATA_WIDTH-1:0] shift_din,
  input  logic [DATA_WIDTH-1:0] shift_dout
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HEAD,
    ST_BODY
  } state_t;

  logic [ADDR_WIDTH:0]   srl_cnt;
  logic [ADDR_WIDTH:0]   srl_cnt_nxt;
  logic [ADDR_WIDTH:0]   srl_cnt_m1;
  logic                  head_valid;
  logic                  head_valid_nxt;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] head_data_nxt;
  state_t                state;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  srl_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srl_cnt    <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      srl_cnt    <= srl_cnt_nxt;
      head_valid <= head_valid_nxt;
      head_data  <= head_data_nxt;
    end
  end

  // The three states are a decode of the occupancy registers, not extra state.
  always_comb begin
    state = ST_EMPTY;
    if (head_valid) begin
      state = (srl_cnt == '0) ? ST_HEAD : ST_BODY;
    end
  end

  always_comb begin
    if_full_n  = (srl_cnt != DEPTH_CNT);
    if_empty_n = head_valid;
    if_dout    = head_data;
    shift_din  = if_din;
    usedw      = {1'b0, srl_cnt} + {{(ADDR_WIDTH+1){1'b0}}, head_valid};
    srl_cnt_m1 = srl_cnt - 1'b1;
    shift_addr = (srl_cnt != '0) ? srl_cnt_m1[ADDR_WIDTH-1:0] : '0;
  end

  always_comb begin
    push    = if_write & if_full_n;
    pop     = if_read & head_valid;
    load    = ~head_valid | pop;
    srl_pop = 1'b0;

    shift_we       = 1'b0;
    head_valid_nxt = head_valid;
    head_data_nxt  = head_data;

    unique case (state)
      ST_EMPTY: begin
        // Head is empty, SRL is empty: an accepted write bypasses to the head.
        if (push) begin
          head_valid_nxt = 1'b1;
          head_data_nxt  = if_din;
        end
      end
      ST_HEAD: begin
        if (pop) begin
          if (push) begin
            head_data_nxt = if_din;
          end else begin
            head_valid_nxt = 1'b0;
          end
        end else begin
          shift_we = push;
        end
      end
      ST_BODY: begin
        // The head reload reads the pre-edge oldest entry while the SRL shifts,
        // so a concurrent write and refill preserve order.
        shift_we = push;
        if (pop) begin
          srl_pop       = 1'b1;
          head_data_nxt = shift_dout;
        end
      end
      default: begin
        head_valid_nxt = 1'b0;
      end
    endcase

    srl_cnt_nxt = srl_cnt;
    if (shift_we && !srl_pop) begin
      srl_cnt_nxt = srl_cnt + 1'b1;
    end else if (!shift_we && srl_pop) begin
      srl_cnt_nxt = srl_cnt - 1'b1;
    end
  end

  // load is fully resolved through the state decode above.
  logic unused_load;
  assign unused_load = load;

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
module tb_start_fifo_srl_ctrl;

  localparam int DW    = 4;
  localparam int AW    = 1;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [AW+1:0] usedw;
  logic          shift_we;
  logic [AW-1:0] shift_addr;
  logic [DW-1:0] shift_din;
  logic [DW-1:0] shift_dout;

  always #5 clk = ~clk;

  start_fifo_srl_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_write  (if_write),
    .if_din    (if_din),
    .if_full_n (if_full_n),
    .if_read   (if_read),
    .if_dout   (if_dout),
    .if_empty_n(if_empty_n),
    .usedw     (usedw),
    .shift_we  (shift_we),
    .shift_addr(shift_addr),
    .shift_din (shift_din),
    .shift_dout(shift_dout)
  );

  // External shift-register storage: entry 0 is newest.
  logic [DW-1:0] srl [DEPTH];
  always_ff @(posedge clk) begin
    if (shift_we) begin
      srl[0] <= shift_din;
      for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
    end
  end
  assign shift_dout = srl[shift_addr];

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the queue model, advance model.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    int  n;
    bit  acc_w;
    bit  acc_r;
    bit  bypass;
    @(negedge clk);
    if_write = w;
    if_din   = d;
    if_read  = r;
    #1;
    n = model_q.size();
    check("empty_n", 32'(if_empty_n), 32'(n > 0));
    check("full_n", 32'(if_full_n), 32'(n < DEPTH + 1));
    check("usedw", 32'(usedw), 32'(n));
    if (n > 0) check("dout", 32'(if_dout), 32'(model_q[0]));
    acc_w  = w && (n < DEPTH + 1);
    acc_r  = r && (n > 0);
    // A write goes straight to the head when nothing older sits in storage
    // and the head is free this cycle.
    bypass = acc_w && (n <= 1) && ((n == 0) || acc_r);
    check("shift_we", 32'(shift_we), 32'(acc_w && !bypass));
    check("shift_addr", 32'(shift_addr), (n >= 2) ? 32'(n - 2) : 32'd0);
    check("shift_addr_range", 32'(int'(shift_addr) < DEPTH), 32'd1);
    check("shift_din", 32'(shift_din), 32'(d));
    if (acc_r) void'(model_q.pop_front());
    if (acc_w) model_q.push_back(d);
  endtask

  initial begin
    rst_n    = 1'b0;
    if_write = 1'b0;
    if_din   = '0;
    if_read  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_empty_n", 32'(if_empty_n), 32'd0);
    check("rst_full_n", 32'(if_full_n), 32'd1);
    check("rst_usedw", 32'(usedw), 32'd0);
    check("rst_dout", 32'(if_dout), 32'd0);
    check("rst_shift_we", 32'(shift_we), 32'd0);
    check("rst_shift_addr", 32'(shift_addr), 32'd0);
    rst_n = 1'b1;

    // Single token through bypass, then read it out.
    step(1, 4'h1, 0);
    step(0, 4'h0, 0);
    check("single_dout", 32'(if_dout), 32'h1);
    step(0, 4'h0, 1);
    step(0, 4'h0, 0);

    // Fill with D rejected, then drain.
    step(1, 4'hA, 0);
    step(1, 4'hB, 0);
    step(1, 4'hC, 0);
    step(1, 4'hD, 0);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 1);
    step(0, 4'h0, 0);

    // Streaming with one entry resident.
    step(1, 4'h0, 0);
    for (int k = 1; k < 20; k++) step(1, DW'(k), 1);
    step(0, 4'h0, 1);
    step(0, 4'h0, 0);

    // Full with concurrent read+write: write rejected, then both accepted.
    step(1, 4'h3, 0);
    step(1, 4'h4, 0);
    step(1, 4'h5, 0);
    step(1, 4'h6, 1);
    step(1, 4'h7, 1);
    step(0, 4'h0, 0);

    // Asynchronous reset with 3 entries held.
    step(1, 4'h8, 0);
    step(0, 4'h0, 0);
    @(negedge clk);
    if_write = 1'b0;
    if_read  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_empty_n", 32'(if_empty_n), 32'd0);
    check("midrst_full_n", 32'(if_full_n), 32'd1);
    check("midrst_usedw", 32'(usedw), 32'd0);
    check("midrst_dout", 32'(if_dout), 32'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 4'h0, 1);
    step(0, 4'h0, 0);

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      step(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)));
    end
    step(0, 4'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
